mmio_bridge: RTL and testbench
==============================

# mmio_bridge

Memory-mapped I/O bridge on the core's data-memory port, between the pipeline's memory stage and `dmem`. It decodes the memory-stage address. Accesses to the I/O window go to local registers: an LED register, a free-running timer with compare flag, and an 8N1 UART transmitter. All other accesses pass through to `dmem`. It replaces the direct PC-driven LED assignment with a software-written LED register.

## Interface
- `CLK_HZ`, default 100_000_000: clock frequency in Hz.
- `BAUD`, default 115200: UART bit rate. Cycles per bit: `BAUD_DIV = CLK_HZ/BAUD`, integer-truncated. Elaboration error if `BAUD_DIV < 2`.
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `a` in 32: memory-stage address (`ALUResultM`).
- `wd` in 32: write data (`WriteDataM`).
- `we` in 1: store strobe (`MemWriteM`).
- `byteEnable` in 4: store byte lanes.
- `rd` out 32: load data returned to the core (`RD_data`).
- `dmem_we` out 1: write enable forwarded to `dmem`.
- `dmem_rd` in 32: read data from `dmem`.
- `led` out 4: LED register.
- `uart_tx` out 1: serial output, idle high.

## Operation
- I/O select: `io_sel = (a[31:16] == 16'hFFFF)`. Offset is `a[7:0]`. Unmapped offsets read 0 and ignore writes.
- `dmem_we = we & ~io_sel`. `rd = io_sel ? io_rdata : dmem_rd`. The read mux is combinational, with the same-cycle read semantics as `dmem`.
- I/O writes require `we`. They commit at the rising edge and honour `byteEnable` per lane.
- 0x00 LED, RW: bits[3:0]. Written when `byteEnable[0]`. Reads zero-extended.
- 0x04 TIMER:
  - Read returns `count`.
  - A write with any lane enabled loads 0, overriding that cycle's increment.
  - Otherwise `count` increments every cycle and wraps 0xFFFF_FFFF → 0.
- 0x08 TIMECMP, RW: byte-writable per lane.
- 0x0C STATUS:
  - bit0 `match` is set the cycle after any cycle in which `count == timecmp`.
  - Writing 1 to bit0 (lane 0) clears it. If set and clear coincide, set wins.
  - bit1 `uart_busy`, read-only. Other bits read 0.
- 0x10 UART_TX, W:
  - With `byteEnable[0]` and UART idle, `wd[7:0]` is latched and transmission starts.
  - Writes while busy are dropped silently. Reads return 0.
- UART FSM states: IDLE → START → DATA → STOP → IDLE.
  - START drives 0, then DATA shifts 8 bits LSB first, then STOP drives 1. Each state holds each bit for `BAUD_DIV` cycles.
  - A bit counter (0..7) and a baud counter (0..BAUD_DIV-1) control the transitions.
  - `uart_busy = (state != IDLE)`.

## Timing
- Reset values:
  - `led` = 0, `count` = 0, `timecmp` = 0xFFFF_FFFF, `match` = 0.
  - UART in IDLE, `uart_tx` = 1, shift register 0.
  - `rd` and `dmem_we` are combinational, so they follow their inputs during reset.
- Register write at edge N is visible on `rd` and outputs from edge N onward, with 0 wait states.
- UART timing:
  - Accepted write at edge N: `uart_tx` falls and `uart_busy` = 1 immediately after edge N.
  - Start bit covers cycles N..N+BAUD_DIV-1. Data bit k starts at N+(1+k)·BAUD_DIV. Stop starts at N+9·BAUD_DIV.
  - Returns to IDLE at edge N+10·BAUD_DIV. A write at that same edge is accepted back-to-back.
- Reset asserted mid-frame: `uart_tx` goes to 1 and the FSM to IDLE immediately, and the frame is lost.
- TIMER write and `count == timecmp` in the same cycle: the match is still flagged, because the compare uses the pre-write value.

## Structure
- Package `mmio_pkg`: I/O base constant (16'hFFFF), offset localparams (`LED_OFF`, `TIMER_OFF`, `TIMECMP_OFF`, `STATUS_OFF`, `UARTTX_OFF`), UART state enum `uart_state_t`.
- Sub-module `uart_tx`:
  - Parameter `BAUD_DIV`.
  - Ports `clk`, `reset`, `start`, `data[7:0]`, `busy`, `tx`.
- Bridge holds the decode, LED/timer/status registers, and the read mux.
- `top` instantiates `mmio_bridge` between `riscv` and `dmem` and drives `LED` from `led`.

## Test plan
- Reset, then check idle outputs: `led` = 0, `uart_tx` = 1, read 0xFFFF0008 → 0xFFFF_FFFF, read 0xFFFF0004 counts up 1 per cycle.
- Store 0x5 to 0xFFFF0000 with `byteEnable` = 4'b0001 → `led` = 4'h5 next cycle. Same store with `byteEnable` = 4'b0000 → no change.
- Store to address 0x0000_0040 → `dmem_we` = 1 and the read returns `dmem_rd`. Store to 0xFFFF0000 → `dmem_we` = 0.
- Compare flag:
  - Write TIMER (→0), write TIMECMP = 20 → STATUS bit0 = 1 about 20 cycles later.
  - W1C clears it.
  - A clear issued in the same cycle as a new match leaves bit0 = 1.
- UART with `CLK_HZ` = 16, `BAUD` = 4 (`BAUD_DIV` = 4):
  - Write 0xA5 → `uart_tx` = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. `busy` is high for exactly 40 cycles.
  - A second write of 0x3C during the frame is dropped.
- Assert `reset` at cycle 15 of a frame → `uart_tx` = 1 and `busy` = 0 asynchronously. Next write starts a clean frame.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared constants and types for the memory-mapped I/O bridge: window base,
// register offsets, UART state encoding and a byte-lane merge helper.
package mmio_pkg;

  localparam logic [15:0] IO_BASE     = 16'hFFFF;
  localparam logic [7:0]  LED_OFF     = 8'h00;
  localparam logic [7:0]  TIMER_OFF   = 8'h04;
  localparam logic [7:0]  TIMECMP_OFF = 8'h08;
  localparam logic [7:0]  STATUS_OFF  = 8'h0C;
  localparam logic [7:0]  UARTTX_OFF  = 8'h10;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

  function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/mmio_if.sv
// Memory-stage bus between the core, the bridge and dmem. The bridge sits on
// the slave side; the core/dmem pair drives the master side.
interface mmio_if;
  logic [31:0] a;
  logic [31:0] wd;
  logic        we;
  logic [3:0]  byteEnable;
  logic [31:0] rd;
  logic        dmem_we;
  logic [31:0] dmem_rd;

  modport slave  (input  a, wd, we, byteEnable, dmem_rd,
                  output rd, dmem_we);
  modport master (output a, wd, we, byteEnable, dmem_rd,
                  input  rd, dmem_we);
endinterface

// File: rtl/mmio_bridge_uart_tx.sv
// 8N1 serial transmitter. A start request is taken when idle, or on the last
// stop-bit cycle so frames can run back to back; otherwise it is ignored.
module uart_tx
  import mmio_pkg::*;
#(
  parameter int BAUD_DIV = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);

  localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  uart_state_t   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          baud_last;

  assign baud_last = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    case (state_q)
      UART_IDLE: begin
        if (start) begin
          state_d = UART_START;
          baud_d  = '0;
          sh_d    = data;
        end
      end
      UART_START: begin
        if (baud_last) begin
          state_d = UART_DATA;
          baud_d  = '0;
          bit_d   = 3'd0;
        end else baud_d = baud_q + 1'b1;
      end
      UART_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          sh_d   = sh_q >> 1;
          if (bit_q == 3'd7) state_d = UART_STOP;
          else bit_d = bit_q + 3'd1;
        end else baud_d = baud_q + 1'b1;
      end
      UART_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // The edge that ends the stop bit can also launch the next frame.
          if (start) begin
            state_d = UART_START;
            sh_d    = data;
          end else state_d = UART_IDLE;
        end else baud_d = baud_q + 1'b1;
      end
      default: state_d = UART_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= UART_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      sh_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

  // Line decoded from state so reset returns it high without waiting for a clock.
  assign busy = (state_q != UART_IDLE);
  assign tx   = (state_q == UART_START) ? 1'b0 :
                (state_q == UART_DATA)  ? sh_q[0] : 1'b1;

endmodule

// File: rtl/mmio_bridge.sv
// Data-memory port bridge: decodes the 0xFFFF_xxxx I/O window into LED, timer,
// compare/status and UART registers; everything else passes through to dmem.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       reset,
  mmio_if.slave      bus,
  output logic [3:0] led,
  output logic       uart_tx
);

  localparam int BAUD_DIV = CLK_HZ / BAUD;

  generate
    if (BAUD_DIV < 2) begin : g_baud_chk
      $error("mmio_bridge: CLK_HZ/BAUD must be at least 2");
    end
  endgenerate

  logic        io_sel, io_wr;
  logic [7:0]  off;
  logic        match_clr, uart_start, uart_busy;
  logic [31:0] io_rdata;
  logic        unused_addr;

  logic [3:0]  led_q, led_d;
  logic [31:0] count_q, count_d;
  logic [31:0] timecmp_q, timecmp_d;
  logic        match_q, match_d;

  assign io_sel      = (bus.a[31:16] == IO_BASE);
  assign off         = bus.a[7:0];
  assign unused_addr = ^bus.a[15:8];
  assign io_wr       = bus.we & io_sel;
  assign match_clr   = io_wr && (off == STATUS_OFF) && bus.byteEnable[0] && bus.wd[0];
  assign uart_start  = io_wr && (off == UARTTX_OFF) && bus.byteEnable[0];

  always_comb begin
    led_d     = led_q;
    count_d   = count_q + 32'd1;
    timecmp_d = timecmp_q;
    match_d   = match_q;
    // Compare uses pre-write values, and a new match beats a same-cycle clear.
    if (match_clr) match_d = 1'b0;
    if (count_q == timecmp_q) match_d = 1'b1;
    if (io_wr) begin
      case (off)
        LED_OFF:     if (bus.byteEnable[0]) led_d = bus.wd[3:0];
        TIMER_OFF:   if (|bus.byteEnable) count_d = 32'd0;
        TIMECMP_OFF: timecmp_d = lane_merge(timecmp_q, bus.wd, bus.byteEnable);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q     <= 4'd0;
      count_q   <= 32'd0;
      timecmp_q <= 32'hFFFF_FFFF;
      match_q   <= 1'b0;
    end else begin
      led_q     <= led_d;
      count_q   <= count_d;
      timecmp_q <= timecmp_d;
      match_q   <= match_d;
    end
  end

  always_comb begin
    io_rdata = 32'd0;
    case (off)
      LED_OFF:     io_rdata = {28'd0, led_q};
      TIMER_OFF:   io_rdata = count_q;
      TIMECMP_OFF: io_rdata = timecmp_q;
      STATUS_OFF:  io_rdata = {30'd0, uart_busy, match_q};
      default:     io_rdata = 32'd0;
    endcase
  end

  assign bus.rd      = io_sel ? io_rdata : bus.dmem_rd;
  assign bus.dmem_we = bus.we & ~io_sel;
  assign led         = led_q;

  uart_tx #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk   (clk),
    .reset (reset),
    .start (uart_start),
    .data  (bus.wd[7:0]),
    .busy  (uart_busy),
    .tx    (uart_tx)
  );

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge with BAUD_DIV = 4 (CLK_HZ 16, BAUD 4).
module tb_mmio_bridge;
  import mmio_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] led;
  logic       tx;
  int         checks = 0;
  int         errors = 0;

  mmio_if bus();

  mmio_bridge #(.CLK_HZ(16), .BAUD(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .led     (led),
    .uart_tx (tx)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic io_wr(input logic [7:0] o, input logic [31:0] d, input logic [3:0] be);
    bus.a = {16'hFFFF, 8'h00, o};
    bus.wd = d;
    bus.byteEnable = be;
    bus.we = 1'b1;
    cyc();
    bus.we = 1'b0;
    bus.byteEnable = 4'd0;
  endtask

  task automatic io_rd(input logic [7:0] o, output logic [31:0] v);
    bus.we = 1'b0;
    bus.a = {16'hFFFF, 8'h00, o};
    #1 v = bus.rd;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (led !== 4'h0) begin errors++; $display("FAIL reset_led got %h exp 0", led); end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
    reset = 1'b0;
    io_rd(TIMECMP_OFF, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_timecmp got %h exp ffffffff", v); end
    cyc();
    io_rd(TIMER_OFF, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL timer_count1 got %0d exp 1", v); end
    cyc();
    io_rd(TIMER_OFF, v);
    checks++; if (v !== 32'd2) begin errors++; $display("FAIL timer_count2 got %0d exp 2", v); end
  endtask

  task automatic test_led();
    logic [31:0] v;
    io_wr(LED_OFF, 32'h5, 4'b0001);
    #1;
    checks++; if (led !== 4'h5) begin errors++; $display("FAIL led_write got %h exp 5", led); end
    io_wr(LED_OFF, 32'hA, 4'b0000);
    #1;
    checks++; if (led !== 4'h5) begin errors++; $display("FAIL led_no_lane got %h exp 5", led); end
    io_wr(LED_OFF, 32'hFFFF_FFFA, 4'b0001);
    io_rd(LED_OFF, v);
    checks++; if (v !== 32'h0000_000A) begin errors++; $display("FAIL led_read got %h exp 0000000a", v); end
  endtask

  task automatic test_passthrough();
    bus.a = 32'h0000_0040;
    bus.wd = 32'h0;
    bus.byteEnable = 4'hF;
    bus.dmem_rd = 32'h1234_5678;
    bus.we = 1'b1;
    #1;
    checks++; if (bus.dmem_we !== 1'b1) begin errors++; $display("FAIL dmem_we_pass got %b exp 1", bus.dmem_we); end
    checks++; if (bus.rd !== 32'h1234_5678) begin errors++; $display("FAIL dmem_rd_pass got %h exp 12345678", bus.rd); end
    bus.a = 32'hFFFF_0000;
    bus.byteEnable = 4'h0;
    #1;
    checks++; if (bus.dmem_we !== 1'b0) begin errors++; $display("FAIL dmem_we_io got %b exp 0", bus.dmem_we); end
    checks++; if (bus.rd !== 32'h0000_000A) begin errors++; $display("FAIL io_read_mux got %h exp 0000000a", bus.rd); end
    bus.a = 32'hFFFF_0020;
    #1;
    checks++; if (bus.rd !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h exp 0", bus.rd); end
    bus.we = 1'b0;
    cyc();
  endtask

  task automatic test_timer_match();
    logic [31:0] v;
    io_rd(STATUS_OFF, v);
    checks++; if (v[0] !== 1'b0) begin errors++; $display("FAIL match_idle got %b exp 0", v[0]); end
    io_wr(TIMER_OFF, 32'h0, 4'hF);
    io_wr(TIMECMP_OFF, 32'd20, 4'hF);
    repeat (19) cyc();
    io_rd(TIMER_OFF, v);
    checks++; if (v !== 32'd20) begin errors++; $display("FAIL timer_reload got %0d exp 20", v); end
    io_rd(STATUS_OFF, v);
    checks++; if (v[0] !== 1'b0) begin errors++; $display("FAIL match_early got %b exp 0", v[0]); end
    cyc();
    io_rd(STATUS_OFF, v);
    checks++; if (v[0] !== 1'b1) begin errors++; $display("FAIL match_set got %b exp 1", v[0]); end
    io_wr(STATUS_OFF, 32'h1, 4'b0001);
    io_rd(STATUS_OFF, v);
    checks++; if (v[0] !== 1'b0) begin errors++; $display("FAIL match_w1c got %b exp 0", v[0]); end
    // Clear lands on the edge that ends the count==timecmp cycle.
    io_wr(TIMER_OFF, 32'h0, 4'hF);
    io_wr(TIMECMP_OFF, 32'd10, 4'hF);
    repeat (9) cyc();
    io_rd(STATUS_OFF, v);
    checks++; if (v[0] !== 1'b0) begin errors++; $display("FAIL match_pre_race got %b exp 0", v[0]); end
    io_wr(STATUS_OFF, 32'h1, 4'b0001);
    io_rd(STATUS_OFF, v);
    checks++; if (v[0] !== 1'b1) begin errors++; $display("FAIL match_set_wins got %b exp 1", v[0]); end
    io_wr(STATUS_OFF, 32'h1, 4'b0001);
    io_rd(STATUS_OFF, v);
    checks++; if (v[0] !== 1'b0) begin errors++; $display("FAIL match_w1c2 got %b exp 0", v[0]); end
    io_wr(TIMECMP_OFF, 32'hAABB_CCDD, 4'b0101);
    io_rd(TIMECMP_OFF, v);
    checks++; if (v !== 32'h00BB_00DD) begin errors++; $display("FAIL timecmp_lanes got %h exp 00bb00dd", v); end
  endtask

  task automatic test_uart();
    logic [9:0]  exp;
    logic [3:0]  k;
    logic [31:0] v;
    exp = {1'b1, 8'hA5, 1'b0};
    io_wr(UARTTX_OFF, 32'hA5, 4'b0001);
    for (int i = 0; i < 40; i++) begin
      bus.a = {16'hFFFF, 8'h00, STATUS_OFF};
      k = 4'(i / 4);
      #1;
      checks++; if (tx !== exp[k]) begin errors++; $display("FAIL uart_a5_bit cyc %0d got %b exp %b", i, tx, exp[k]); end
      checks++; if (bus.rd[1] !== 1'b1) begin errors++; $display("FAIL uart_busy cyc %0d got %b exp 1", i, bus.rd[1]); end
      if (i == 5) begin
        bus.a = {16'hFFFF, 8'h00, UARTTX_OFF};
        bus.wd = 32'h3C;
        bus.byteEnable = 4'b0001;
        bus.we = 1'b1;
      end
      cyc();
      bus.we = 1'b0;
      bus.byteEnable = 4'd0;
    end
    io_rd(STATUS_OFF, v);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL uart_end_tx got %b exp 1", tx); end
    checks++; if (v[1] !== 1'b0) begin errors++; $display("FAIL uart_end_busy got %b exp 0", v[1]); end
    io_rd(UARTTX_OFF, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL uart_read got %h exp 0", v); end
  endtask

  task automatic test_back_to_back();
    logic [9:0]  exp;
    logic [3:0]  k;
    logic [31:0] v;
    exp = {1'b1, 8'h80, 1'b0};
    io_wr(UARTTX_OFF, 32'h80, 4'b0001);
    for (int i = 0; i < 40; i++) begin
      bus.a = {16'hFFFF, 8'h00, STATUS_OFF};
      k = 4'(i / 4);
      #1;
      checks++; if (tx !== exp[k]) begin errors++; $display("FAIL b2b_80_bit cyc %0d got %b exp %b", i, tx, exp[k]); end
      if (i == 39) begin
        bus.a = {16'hFFFF, 8'h00, UARTTX_OFF};
        bus.wd = 32'h01;
        bus.byteEnable = 4'b0001;
        bus.we = 1'b1;
      end
      cyc();
      bus.we = 1'b0;
      bus.byteEnable = 4'd0;
    end
    io_rd(STATUS_OFF, v);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL b2b_start got %b exp 0", tx); end
    checks++; if (v[1] !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b exp 1", v[1]); end
    repeat (4) cyc();
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL b2b_data0 got %b exp 1", tx); end
    repeat (36) cyc();
    io_rd(STATUS_OFF, v);
    checks++; if (tx !== 1'b1 || v[1] !== 1'b0) begin errors++; $display("FAIL b2b_idle got tx %b busy %b exp 1 0", tx, v[1]); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] v;
    io_wr(UARTTX_OFF, 32'h00, 4'b0001);
    repeat (15) cyc();
    #1;
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL midframe_pre got %b exp 0", tx); end
    bus.a = {16'hFFFF, 8'h00, STATUS_OFF};
    reset = 1'b1;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midframe_rst_tx got %b exp 1", tx); end
    checks++; if (bus.rd[1] !== 1'b0) begin errors++; $display("FAIL midframe_rst_busy got %b exp 0", bus.rd[1]); end
    checks++; if (led !== 4'h0) begin errors++; $display("FAIL midframe_rst_led got %h exp 0", led); end
    @(negedge clk);
    reset = 1'b0;
    io_wr(UARTTX_OFF, 32'h01, 4'b0001);
    #1;
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL clean_start got %b exp 0", tx); end
    repeat (4) cyc();
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL clean_data0 got %b exp 1", tx); end
    repeat (4) cyc();
    #1;
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL clean_data1 got %b exp 0", tx); end
    repeat (32) cyc();
    io_rd(STATUS_OFF, v);
    checks++; if (tx !== 1'b1 || v[1] !== 1'b0) begin errors++; $display("FAIL clean_idle got tx %b busy %b exp 1 0", tx, v[1]); end
  endtask

  initial begin
    bus.a = 32'h0;
    bus.wd = 32'h0;
    bus.we = 1'b0;
    bus.byteEnable = 4'h0;
    bus.dmem_rd = 32'h0;
    test_reset();
    test_led();
    test_passthrough();
    test_timer_match();
    test_uart();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
